midi_voice_dispatch: RTL and testbench

//  Decodes the MIDI byte stream from the UART receiver, including running status, into voice events.

---
 rtl/midi_voice_dispatch_if.sv | 29 ++
 rtl/midi_voice_dispatch.sv | 193 +++++++++++++++++++
 tb/tb_midi_voice_dispatch.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_voice_dispatch_if.sv
// rtl/midi_voice_dispatch_if.sv - MIDI byte input and synth voice event bus
interface midi_voice_dispatch_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]      rx_byte;
    logic            rx_valid;
    logic            rx_ready;
    logic            note_pressed;
    logic            note_released;
    logic            note_keypress;
    logic            pitch_wheel;
    logic [6:0]      note;
    logic [6:0]      velocity;
    logic [3:0]      channel;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0] active_count;

    modport master (
        output rx_byte, rx_valid,
        input  rx_ready, note_pressed, note_released, note_keypress, pitch_wheel,
        input  note, velocity, channel, addr, active_count
    );

    modport slave (
        input  rx_byte, rx_valid,
        output rx_ready, note_pressed, note_released, note_keypress, pitch_wheel,
        output note, velocity, channel, addr, active_count
    );
endinterface

// File: rtl/midi_voice_dispatch.sv
// rtl/midi_voice_dispatch.sv - MIDI running-status decoder with voice slot allocation
module midi_voice_dispatch #(
    parameter int NUM_VOICES = 128,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk96,
    input  logic                  rst,
    midi_voice_dispatch_if.slave  bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [ADDR_W:0]  ACT_MAX  = (ADDR_W + 1)'(NUM_VOICES);
    localparam logic [ADDR_W:0]  ACT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_DATA1, S_DATA2, S_SCAN, S_EMIT} state_t;

    state_t            state_q;
    logic [7:0]        status_q;
    logic [6:0]        d1_q, d2_q;
    logic [IDX_W-1:0]  scan_idx_q, steal_ptr_q;
    logic              match_found_q, free_found_q;
    logic [IDX_W-1:0]  match_idx_q, free_idx_q;
    logic              match_found_d, free_found_d;
    logic [IDX_W-1:0]  match_idx_d, free_idx_d;

    logic              slot_valid_q [NUM_VOICES];
    logic [3:0]        slot_ch_q    [NUM_VOICES];
    logic [6:0]        slot_note_q  [NUM_VOICES];

    logic              rx_ready_q, pressed_q, released_q, keypress_q, pitch_q;
    logic [6:0]        note_q, velocity_q;
    logic [3:0]        channel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   active_q;

    logic accept, hit, is_note_on, is_note_off;

    assign accept      = bus.rx_valid & rx_ready_q;
    assign hit         = slot_valid_q[scan_idx_q] && (slot_ch_q[scan_idx_q] == status_q[3:0])
                         && (slot_note_q[scan_idx_q] == d1_q);
    assign is_note_on  = (status_q[7:4] == 4'h9) && (d2_q != 7'd0);
    assign is_note_off = (status_q[7:4] == 4'h8) || ((status_q[7:4] == 4'h9) && (d2_q == 7'd0));

    // Fold the slot under the scan pointer into the first-match / first-free results.
    always_comb begin
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        if (!match_found_q && hit) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx_q;
        end
        if (!free_found_q && !slot_valid_q[scan_idx_q]) begin
            free_found_d = 1'b1;
            free_idx_d   = scan_idx_q;
        end
    end

    always_ff @(posedge clk96) begin
        if (rst) begin
            state_q       <= S_IDLE;
            status_q      <= '0;
            d1_q          <= '0;
            d2_q          <= '0;
            scan_idx_q    <= '0;
            steal_ptr_q   <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) slot_valid_q[i] <= 1'b0;
            rx_ready_q    <= 1'b1;
            pressed_q     <= 1'b0;
            released_q    <= 1'b0;
            keypress_q    <= 1'b0;
            pitch_q       <= 1'b0;
            note_q        <= '0;
            velocity_q    <= '0;
            channel_q     <= '0;
            addr_q        <= '0;
            active_q      <= '0;
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            keypress_q <= 1'b0;
            pitch_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_DATA1, S_DATA2: begin
                    if (accept) begin
                        if (bus.rx_byte >= 8'hF8) begin
                            state_q <= state_q;
                        end else if (bus.rx_byte >= 8'hF0) begin
                            state_q <= S_IDLE;
                        end else if (bus.rx_byte[7]) begin
                            status_q <= bus.rx_byte;
                            state_q  <= S_DATA1;
                        end else if (state_q == S_DATA1) begin
                            d1_q    <= bus.rx_byte[6:0];
                            state_q <= ((status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD))
                                       ? S_DATA1 : S_DATA2;
                        end else if (state_q == S_DATA2) begin
                            d2_q <= bus.rx_byte[6:0];
                            case (status_q[7:4])
                                4'hB: state_q <= S_DATA1;
                                4'hE: begin
                                    // Pitch bend: 2nd byte is the MSB, reported on note.
                                    pitch_q    <= 1'b1;
                                    note_q     <= bus.rx_byte[6:0];
                                    velocity_q <= d1_q;
                                    channel_q  <= status_q[3:0];
                                    addr_q     <= '0;
                                    rx_ready_q <= 1'b0;
                                    state_q    <= S_EMIT;
                                end
                                default: begin
                                    scan_idx_q    <= '0;
                                    match_found_q <= 1'b0;
                                    free_found_q  <= 1'b0;
                                    rx_ready_q    <= 1'b0;
                                    state_q       <= S_SCAN;
                                end
                            endcase
                        end
                    end
                end
                S_SCAN: begin
                    match_found_q <= match_found_d;
                    match_idx_q   <= match_idx_d;
                    free_found_q  <= free_found_d;
                    free_idx_q    <= free_idx_d;
                    if (scan_idx_q != LAST_IDX) begin
                        scan_idx_q <= scan_idx_q + IDX_W'(1);
                    end else begin
                        state_q <= S_EMIT;
                        if (is_note_on || match_found_d) begin
                            note_q     <= d1_q;
                            velocity_q <= d2_q;
                            channel_q  <= status_q[3:0];
                        end
                        if (is_note_on) begin
                            pressed_q <= 1'b1;
                            if (match_found_d) begin
                                addr_q <= ADDR_W'(match_idx_d);
                            end else if (free_found_d) begin
                                addr_q                   <= ADDR_W'(free_idx_d);
                                slot_valid_q[free_idx_d] <= 1'b1;
                                slot_ch_q[free_idx_d]    <= status_q[3:0];
                                slot_note_q[free_idx_d]  <= d1_q;
                                if (active_q != ACT_MAX) active_q <= active_q + ACT_ONE;
                            end else begin
                                // Table full: round-robin steal, slot stays valid.
                                addr_q                   <= ADDR_W'(steal_ptr_q);
                                slot_ch_q[steal_ptr_q]   <= status_q[3:0];
                                slot_note_q[steal_ptr_q] <= d1_q;
                                steal_ptr_q <= (steal_ptr_q == LAST_IDX) ? '0
                                               : steal_ptr_q + IDX_W'(1);
                            end
                        end else if (match_found_d) begin
                            addr_q <= ADDR_W'(match_idx_d);
                            if (is_note_off) begin
                                released_q                <= 1'b1;
                                slot_valid_q[match_idx_d] <= 1'b0;
                                if (active_q != '0) active_q <= active_q - ACT_ONE;
                            end else begin
                                keypress_q <= 1'b1;
                            end
                        end
                    end
                end
                S_EMIT: begin
                    rx_ready_q <= 1'b1;
                    state_q    <= S_DATA1;
                end
                default: begin
                    rx_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rx_ready      = rx_ready_q;
    assign bus.note_pressed  = pressed_q;
    assign bus.note_released = released_q;
    assign bus.note_keypress = keypress_q;
    assign bus.pitch_wheel   = pitch_q;
    assign bus.note          = note_q;
    assign bus.velocity      = velocity_q;
    assign bus.channel       = channel_q;
    assign bus.addr          = addr_q;
    assign bus.active_count  = active_q;
endmodule

// File: tb/tb_midi_voice_dispatch.sv
// tb/tb_midi_voice_dispatch.sv - randomized bench with a voice-table reference model
module tb_midi_voice_dispatch;
    localparam logic [3:0] K_PRESS = 4'b1000, K_REL = 4'b0100, K_KEY = 4'b0010, K_PB = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    midi_voice_dispatch_if #(.ADDR_W(8)) bus_l ();
    midi_voice_dispatch_if #(.ADDR_W(8)) bus_s ();

    midi_voice_dispatch #(.NUM_VOICES(128), .ADDR_W(8)) u_dut_l (.clk96(clk), .rst(rst), .bus(bus_l.slave));
    midi_voice_dispatch #(.NUM_VOICES(4),   .ADDR_W(8)) u_dut_s (.clk96(clk), .rst(rst), .bus(bus_s.slave));

    logic [7:0] rx_byte = '0;
    logic       rx_valid = 1'b0;
    logic       sel = 1'b0;

    assign bus_l.rx_byte  = rx_byte;
    assign bus_l.rx_valid = rx_valid & ~sel;
    assign bus_s.rx_byte  = rx_byte;
    assign bus_s.rx_valid = rx_valid & sel;

    logic       rdy;
    logic [3:0] strb, o_ch;
    logic [6:0] o_note, o_vel;
    logic [7:0] o_addr;
    logic [8:0] o_act;
    assign rdy    = sel ? bus_s.rx_ready : bus_l.rx_ready;
    assign strb   = sel ? {bus_s.note_pressed, bus_s.note_released, bus_s.note_keypress, bus_s.pitch_wheel}
                        : {bus_l.note_pressed, bus_l.note_released, bus_l.note_keypress, bus_l.pitch_wheel};
    assign o_note = sel ? bus_s.note : bus_l.note;
    assign o_vel  = sel ? bus_s.velocity : bus_l.velocity;
    assign o_ch   = sel ? bus_s.channel : bus_l.channel;
    assign o_addr = sel ? bus_s.addr : bus_l.addr;
    assign o_act  = sel ? bus_s.active_count : bus_l.active_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_acc    = 0;
    int last_strobe_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: running-status parser plus a voice table searched in slot order.
    typedef struct {
        logic [3:0] kind;
        int note, vel, ch, addr, act;
    } ev_t;

    ev_t exp_q[$];
    bit  mv[128];
    int  mch[128], mnote[128];
    int  nv = 128, steal = 0, mcount = 0;
    bit  m_have = 0;
    int  m_stat = 0, m_cnt = 0, m_d1 = 0;

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mv[i] = 0;
        steal = 0; mcount = 0; m_have = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    function automatic int find_match(int ch, int n);
        for (int i = 0; i < nv; i++) if (mv[i] && mch[i] == ch && mnote[i] == n) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < nv; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    task automatic model_msg(int hi, int ch, int d1, int d2);
        int m, a;
        m = find_match(ch, d1);
        if (hi == 14) begin
            exp_q.push_back('{K_PB, d2, d1, ch, 0, mcount});
        end else if (hi == 9 && d2 != 0) begin
            if (m >= 0) a = m;
            else begin
                a = find_free();
                if (a >= 0) begin
                    mv[a] = 1; mcount++;
                end else begin
                    a = steal;
                    steal = (steal + 1) % nv;
                end
                mch[a] = ch; mnote[a] = d1;
            end
            exp_q.push_back('{K_PRESS, d1, d2, ch, a, mcount});
        end else if (hi == 8 || hi == 9) begin
            if (m >= 0) begin
                mv[m] = 0; mcount--;
                exp_q.push_back('{K_REL, d1, d2, ch, m, mcount});
            end
        end else if (hi == 10 && m >= 0) begin
            exp_q.push_back('{K_KEY, d1, d2, ch, m, mcount});
        end
    endtask

    task automatic model_byte(int b);
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin m_have = 0; m_cnt = 0; return; end
        if (b >= 'h80) begin m_stat = b; m_have = 1; m_cnt = 0; return; end
        if (!m_have) return;
        if (m_cnt == 0) begin
            m_d1 = b;
            m_cnt = ((m_stat >> 4) == 12 || (m_stat >> 4) == 13) ? 0 : 1;
        end else begin
            m_cnt = 0;
            model_msg(m_stat >> 4, m_stat & 15, m_d1, b);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_byte = b; rx_valid = 1'b1;
        while (!rdy && n < 400) begin @(negedge clk); n++; end
        if (!rdy) chk("ready_timeout", {31'd0, rdy}, 1);
        t_acc = cyc;
        model_byte(int'(b));
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Monitor: every strobe is compared against the next model event.
    logic pend = 1'b0, pend_scan = 1'b0;
    ev_t  pend_ev;
    always @(negedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                chk("act_after", o_act, pend_ev.act);
                chk("hold_note", o_note, pend_ev.note);
                chk("hold_addr", o_addr, pend_ev.addr);
                if (pend_scan) chk("ready_back", {31'd0, rdy}, 1);
                pend <= 1'b0;
            end
            if (strb != 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", strb, 0);
                end else begin
                    chk("strobe_kind", strb, exp_q[0].kind);
                    chk("note", o_note, exp_q[0].note);
                    chk("velocity", o_vel, exp_q[0].vel);
                    chk("channel", o_ch, exp_q[0].ch);
                    chk("addr", o_addr, exp_q[0].addr);
                    if (exp_q[0].kind != K_PB) chk("ready_in_emit", {31'd0, rdy}, 0);
                    last_strobe_cyc <= cyc;
                    pend      <= 1'b1;
                    pend_ev   <= exp_q[0];
                    pend_scan <= (exp_q[0].kind != K_PB);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((exp_q.size() != 0 || !rdy || pend) && n < 600);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    logic [7:0] seq_b;
    int hi, nb, t1;
    int steal_addrs[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        sel = 1'b0; nv = 128;
        do_reset();
        @(negedge clk);
        chk("rst_ready", {31'd0, rdy}, 1);
        chk("rst_strobes", strb, 0);
        chk("rst_act", o_act, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_note", o_note, 0);

        send(8'h90); send(8'h3C); send(8'h64); t1 = t_acc;
        wait_idle();
        chk("lat_note_on", last_strobe_cyc - t1, 129);
        chk("t1_note", o_note, 60);
        chk("t1_vel", o_vel, 100);
        chk("t1_addr", o_addr, 0);
        chk("t1_act", o_act, 1);

        send(8'h3E); send(8'h50); wait_idle();
        chk("t2_addr", o_addr, 1);
        send(8'h3C); send(8'h00); wait_idle();
        chk("t2_rel_addr", o_addr, 0);
        chk("t2_act", o_act, 1);

        send(8'hE3); send(8'h00); send(8'h50); t1 = t_acc; wait_idle();
        chk("lat_pb", last_strobe_cyc - t1, 1);
        chk("pb_note", o_note, 8'h50);
        send(8'hE3); send(8'h00); send(8'hF8); send(8'h50); t1 = t_acc; wait_idle();
        chk("lat_pb_rt", last_strobe_cyc - t1, 1);

        send(8'hA0); send(8'h40); send(8'h20); wait_idle();
        send(8'h90); send(8'h40); send(8'h10);
        send(8'hA0); send(8'h40); send(8'h20); wait_idle();
        chk("key_vel", o_vel, 32);

        send(8'h90); send(8'h3C); send(8'hF0); send(8'h3C); send(8'h64); wait_idle();
        send(8'h90); send(8'h3D); send(8'h64);
        repeat (20) @(negedge clk);
        do_reset();
        repeat (140) @(negedge clk);
        chk("midscan_act", o_act, 0);
        chk("midscan_ready", {31'd0, rdy}, 1);

        sel = 1'b1; nv = 4;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) send(8'h90);
            seq_b = 8'h30 + 8'(i);
            send(seq_b); send(8'h28); wait_idle();
            chk("steal_addr", o_addr, steal_addrs[i]);
        end
        chk("steal_act", o_act, 4);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 6) send(8'hF0 + 8'($urandom_range(0, 7)));
            else if (r < 10) send(8'($urandom_range(0, 127)));
            else begin
                case ($urandom_range(0, 8))
                    0: hi = 8; 1, 2, 3: hi = 9; 4: hi = 10; 5: hi = 11;
                    6: hi = 12; 7: hi = 13; default: hi = 14;
                endcase
                if ($urandom_range(0, 2) != 0) send(8'((hi << 4) | $urandom_range(0, 1)));
                nb = (hi == 12 || hi == 13) ? 1 : 2;
                for (int j = 0; j < nb; j++) begin
                    if ($urandom_range(0, 5) == 0) send(8'hF8 + 8'($urandom_range(0, 7)));
                    if (j == 0) send(8'(60 + $urandom_range(0, 5)));
                    else send(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 127)));
                end
            end
        end
        wait_idle();
        chk("final_act", o_act, mcount);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
